// File: rtl/store_buffer_align_pkg.sv
// Shared RV32I types for the store path: store funct3 encoding, word type, queued store entry.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic [29:0] addr;
    rv32i_word   wdata;
    logic [3:0]  be;
  } st_entry_t;

  typedef enum logic {
    DRAIN_IDLE  = 1'b0,
    DRAIN_WRITE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/store_buffer_align_wdata_align_logic.sv
// Combinational store aligner: replicates rs2 data into byte lanes and builds the byte-enable mask.
module wdata_align_logic
  import rv32i_types::*;
(
  input  logic [1:0] off,
  input  logic [2:0] funct3,
  input  rv32i_word  data,
  output rv32i_word  wdata,
  output logic [3:0] be,
  output logic       misalign,
  output logic       legal
);

  always_comb begin
    wdata    = '0;
    be       = '0;
    misalign = 1'b0;
    legal    = 1'b1;
    case (store_funct3_t'(funct3))
      sb: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << off;
      end
      sh: begin
        wdata    = {2{data[15:0]}};
        be       = off[1] ? 4'b1100 : 4'b0011;
        misalign = off[0];
      end
      sw: begin
        wdata    = data;
        be       = 4'b1111;
        misalign = (off != 2'b00);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_buffer_align.sv
// Store buffer: aligns stores, queues them in a DEPTH-entry FIFO and drains them in order to the
// cache write port; flags loads that hit any pending store word (including the one in flight).
module store_buffer_align
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_data,
  output logic        st_misalign,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_write,
  input  logic        mem_resp,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  st_entry_t    fifo [DEPTH];
  logic [PW:0]  wr_ptr, rd_ptr;
  logic [PW:0]  count;
  logic         fifo_empty, full, has_next;
  logic         accept, push, pop, load;
  drain_state_t state, next_state;
  st_entry_t    new_entry, load_entry;
  rv32i_word    al_wdata;
  logic [3:0]   al_be;
  logic         al_misalign, al_legal;

  wdata_align_logic u_align (
    .off      (st_addr[1:0]),
    .funct3   (st_funct3),
    .data     (st_data),
    .wdata    (al_wdata),
    .be       (al_be),
    .misalign (al_misalign),
    .legal    (al_legal)
  );

  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign has_next   = (count > CW'(1));
  assign st_ready   = !full;
  assign accept     = st_valid && st_ready;
  assign push       = accept && al_legal && !al_misalign;
  assign new_entry  = '{addr: st_addr[31:2], wdata: al_wdata, be: al_be};
  assign empty      = fifo_empty && (state == DRAIN_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DRAIN_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      DRAIN_IDLE:  if (!fifo_empty) next_state = DRAIN_WRITE;
      DRAIN_WRITE: if (mem_resp && !has_next) next_state = DRAIN_IDLE;
      default:     next_state = DRAIN_IDLE;
    endcase
  end

  // The in-flight store stays at the FIFO head until acknowledged, so the next one is head+1.
  always_comb begin
    mem_write  = (state == DRAIN_WRITE);
    pop        = (state == DRAIN_WRITE) && mem_resp;
    load       = ((state == DRAIN_IDLE) && !fifo_empty) || (pop && has_next);
    load_entry = (state == DRAIN_WRITE) ? fifo[rd_ptr[PW-1:0] + PW'(1)] : fifo[rd_ptr[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[PW-1:0]] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      st_misalign <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
      st_misalign <= accept && al_legal && al_misalign;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else if (load) begin
      mem_address     <= {load_entry.addr, 2'b00};
      mem_wdata       <= load_entry.wdata;
      mem_byte_enable <= load_entry.be;
    end
  end

  always_comb begin
    ld_conflict = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (fifo[rd_ptr[PW-1:0] + PW'(k)].addr == ld_addr[31:2]))
        ld_conflict = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer_align.sv
// Scoreboard bench for store_buffer_align: directed stores push expected writes, a monitor checks them.
module tb_store_buffer_align;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [2:0]  st_funct3 = '0;
  logic [31:0] st_data = '0;
  logic        st_misalign;
  logic [31:0] ld_addr = 32'hFFFF_FFF0;
  logic        ld_conflict;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_write;
  logic        mem_resp = 1'b0;
  logic        empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  store_buffer_align #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_funct3(st_funct3), .st_data(st_data), .st_misalign(st_misalign), .ld_addr(ld_addr),
    .ld_conflict(ld_conflict), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_write(mem_write), .mem_resp(mem_resp), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one store and returns 1 ns after the edge that accepted it.
  task automatic store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    st_valid = 1'b1; st_funct3 = f; st_addr = a; st_data = d;
    while (!st_ready && n < 50) begin tick(1); n++; end
    if (n >= 50) check("store_accept_timeout", 32'd0, 32'd1);
    tick(1);
    st_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b);
    exp_t e;
    e.addr = a; e.wdata = w; e.be = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!empty && n < 50) begin tick(1); n++; end
    if (n >= 50) check("drain_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst && mem_write && mem_resp) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", mem_address, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", mem_address, e.addr);
        check("wr_data", mem_wdata, e.wdata);
        check("wr_be", {28'd0, mem_byte_enable}, {28'd0, e.be});
      end
    end
  end

  initial begin
    int hi;
    #3;
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_st_ready", {31'd0, st_ready}, 32'd1);
    check("rst_mem_address", mem_address, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rst_misalign", {31'd0, st_misalign}, 32'd0);
    check("rst_be", {28'd0, mem_byte_enable}, 32'd0);

    // 1: sb to byte 3
    expect_wr(32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
    store(3'b000, 32'h0000_1003, 32'h0000_00AB);
    check("t1_not_empty", {31'd0, empty}, 32'd0);
    tick(1);
    check("t1_latency_mem_write", {31'd0, mem_write}, 32'd1);
    mem_resp = 1'b1;
    wait_empty();
    mem_resp = 1'b0;

    // 2: back-to-back sh/sw with resp held high
    mem_resp = 1'b1;
    expect_wr(32'h0000_2000, 32'h1234_1234, 4'b1100);
    expect_wr(32'h0000_2004, 32'hDEAD_BEEF, 4'b1111);
    store(3'b001, 32'h0000_2002, 32'h0000_1234);
    store(3'b010, 32'h0000_2004, 32'hDEAD_BEEF);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_write) hi++;
      tick(1);
    end
    check("t2_write_cycles", hi, 32'd2);
    mem_resp = 1'b0;
    wait_empty();

    // 3: fill, then enqueue attempt coincident with a pop
    expect_wr(32'h0000_5000, 32'h1111_1111, 4'b0001);
    expect_wr(32'h0000_5000, 32'h2222_2222, 4'b0010);
    expect_wr(32'h0000_5000, 32'h3333_3333, 4'b0100);
    expect_wr(32'h0000_5000, 32'h4444_4444, 4'b1000);
    store(3'b000, 32'h0000_5000, 32'h11);
    store(3'b000, 32'h0000_5001, 32'h22);
    store(3'b000, 32'h0000_5002, 32'h33);
    store(3'b000, 32'h0000_5003, 32'h44);
    check("t3_full_not_ready", {31'd0, st_ready}, 32'd0);
    st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 32'h0000_6000; st_data = 32'h5555_5555;
    mem_resp = 1'b1;
    tick(1);
    st_valid = 1'b0; mem_resp = 1'b0;
    check("t3_ready_after_pop", {31'd0, st_ready}, 32'd1);
    ld_addr = 32'h0000_6000;
    #1;
    check("t3_no_enqueue_when_full", {31'd0, ld_conflict}, 32'd0);
    mem_resp = 1'b1;
    wait_empty();
    mem_resp = 1'b0;

    // 4: misaligned sw dropped, unknown funct3 silently discarded
    store(3'b010, 32'h0000_3001, 32'hCAFE_F00D);
    check("t4_misalign_pulse", {31'd0, st_misalign}, 32'd1);
    check("t4_empty", {31'd0, empty}, 32'd1);
    tick(1);
    check("t4_misalign_once", {31'd0, st_misalign}, 32'd0);
    check("t4_empty_later", {31'd0, empty}, 32'd1);
    store(3'b111, 32'h0000_3000, 32'h1);
    check("t4_illegal_no_pulse", {31'd0, st_misalign}, 32'd0);
    check("t4_illegal_empty", {31'd0, empty}, 32'd1);

    // 5: load conflict against pending store
    expect_wr(32'h0000_4004, 32'h7777_7777, 4'b0010);
    store(3'b000, 32'h0000_4005, 32'h77);
    ld_addr = 32'h0000_4006;
    #1;
    check("t5_conflict_same_word", {31'd0, ld_conflict}, 32'd1);
    tick(1);
    check("t5_conflict_in_flight", {31'd0, ld_conflict}, 32'd1);
    ld_addr = 32'h0000_4008;
    #1;
    check("t5_no_conflict_next_word", {31'd0, ld_conflict}, 32'd0);
    mem_resp = 1'b1;
    wait_empty();
    mem_resp = 1'b0;
    ld_addr = 32'h0000_4006;
    #1;
    check("t5_no_conflict_after_drain", {31'd0, ld_conflict}, 32'd0);

    // 6: reset mid-write abandons the transfer
    store(3'b010, 32'h0000_7000, 32'h1122_3344);
    tick(1);
    check("t6_writing", {31'd0, mem_write}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("t6_rst_empty", {31'd0, empty}, 32'd1);
    check("t6_rst_addr", mem_address, 32'd0);
    tick(1);
    rst = 1'b1;
    mem_resp = 1'b1;
    hi = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (mem_write || !empty) hi++;
    end
    check("t6_post_rst_resp_ignored", hi, 32'd0);
    mem_resp = 1'b0;

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
